axil_led_pwm: RTL and testbench
===============================

Name: axil_led_pwm

Overview:
- AXI-Lite slave driving NUM_CH LEDs; each channel is independently off, on, PWM-dimmed or blinking.
- Parametrised successor to the fixed 4-word LED memory: configurable channel count, shared tick prescaler, per-channel mode/duty/blink registers, read-only status, SLVERR decode.
- Sits on the SoC AXI-Lite peripheral bus; `leds` go straight to board pins.

Parameters:
- C_AXI_ADDR_WIDTH, 6: byte address width; must cover 4*(2+NUM_CH) bytes.
- NUM_CH, 8: LED channel count, 1..(2**(C_AXI_ADDR_WIDTH-2))-2.
- OPT_LOWPOWER, 0: when 1, s_axi_rdata is forced to 0 whenever s_axi_rvalid=0.

Ports:
- s_axi_aclk, in, 1: single clock.
- s_axi_aresetn, in, 1: asynchronous, active-low reset.
- s_axi_awvalid/awready/awaddr/awprot: in/out/in/in, 1/1/C_AXI_ADDR_WIDTH/3: write address.
- s_axi_wvalid/wready/wdata/wstrb: in/out/in/in, 1/1/32/4: write data.
- s_axi_bvalid/bready/bresp: out/in/out, 1/1/2: write response.
- s_axi_arvalid/arready/araddr/arprot: in/out/in/in, 1/1/C_AXI_ADDR_WIDTH/3: read address.
- s_axi_rvalid/rready/rdata/rresp: out/in/out/out, 1/1/32/2: read data.
- leds, out, NUM_CH: LED drive, bit k = channel k.

Behaviour:
- Word map, index = addr[C_AXI_ADDR_WIDTH-1:2]:
  - 0 CTRL: [0] enable, [23:8] prescale P.
  - 1 STATUS (RO): [NUM_CH-1:0] current leds, other bits 0.
  - 2+k CH_k: [1:0] mode (0 off, 1 on, 2 pwm, 3 blink), [15:8] duty, [31:16] half-period H.
  - Unused register bits read 0.
- Reset (async assert, sync release is the integrator's job):
  - All registers 0; leds=0.
  - awready=wready=bvalid=rvalid=0; rdata=0; prescaler, PWM and blink counters 0.
- Write handshake:
  - awready=wready pulse for one cycle when awvalid&&wvalid&&!awready&&(!bvalid||bready).
  - bvalid rises the next cycle and stays high until bready.
  - wstrb is byte-granular.
- Write responses:
  - STATUS write: ignored, bresp=OKAY.
  - Index >= 2+NUM_CH: ignored, bresp=SLVERR(2'b10).
  - All other writes: bresp=OKAY.
- Read handshake:
  - arready = !rvalid.
  - On accept, rdata/rresp are registered; rvalid rises the next cycle and holds until rready.
  - Out-of-range read: rdata=0, rresp=SLVERR.
- Simultaneous read and write to the same word in the same cycle: the read returns the pre-write value.
- Tick generation:
  - pre_cnt counts 0..P; tick=1 in the cycle pre_cnt==P, then pre_cnt wraps to 0.
  - P=0 gives a tick every cycle.
- PWM:
  - 8-bit pwm_cnt increments on each tick and wraps 255->0.
  - pwm led = (pwm_cnt < duty).
  - duty=0 gives always off; duty=255 gives 255/256 on.
- Blink, per channel:
  - 16-bit counter increments on tick.
  - When counter reaches max(H,1)-1 on a tick, the counter clears and the phase toggles; led=phase.
- Off: led=0. On: led=1.
- Any accepted write to CH_k (any strobe) clears that channel's blink counter and sets phase=1 on the following cycle.
- Register output: leds are registered; a change appears one cycle after the cause (register write, or the tick that moves the counter).
- enable=0:
  - pre_cnt, pwm_cnt and all blink counters are held at 0 and phases at 1; leds=0.
  - Registers remain readable and writable.
- awprot/arprot are ignored.

Decomposition:
- Package axil_led_pkg holds:
  - Word indices ADDR_CTRL=0, ADDR_STATUS=1, ADDR_CH0=2.
  - Mode encodings MODE_OFF/ON/PWM/BLINK.
  - RESP_OKAY/RESP_SLVERR.
  - Field bit positions.
- Sub-module led_chan_gen, instantiated NUM_CH times:
  - Inputs: tick, pwm_cnt, mode, duty, H, restart, enable.
  - Output: one registered led.
  - Contains the blink counter and phase.
- The top holds the AXI-Lite logic, register file, prescaler and pwm_cnt.

Test Plan:
- Reset with NUM_CH=8, then read words 0..9 -> all 0, rresp OKAY; leds=8'h00.
- Write CTRL=0x0000_0001, CH3=0x0000_0001 -> leds=8'h08 one cycle after bvalid; STATUS reads 0x08.
- CTRL P=0, enable=1; CH0 mode=pwm, duty=64 -> leds[0] high for exactly 64 of every 256 cycles.
- CTRL P=3; CH1 mode=blink, H=5 -> leds[1] toggles every 20 cycles, starting high after the write.
- Write 0xFFFF_FFFF with wstrb=4'b0010 to CH2, then read -> 0x0000_FF00. Write to word 12 -> bresp=SLVERR, no register changes. Read word 12 -> rdata 0, rresp=SLVERR.
- Hold rready=0 with bready=0 and back-to-back requests -> rvalid/bvalid hold and no second accept until the ready. Assert s_axi_aresetn=0 mid-blink -> leds=0 and bvalid=rvalid=0 immediately (asynchronous).

Source files
------------

// File: rtl/axil_led_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_led_pkg
// Description : Shared constants for the AXI-Lite LED PWM/blink peripheral:
//               word indices, channel mode encodings, AXI response codes and
//               register field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_led_pkg;

    // Word indices (byte address >> 2)
    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_CH0    = 2;

    // Per-channel drive mode
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    // AXI responses
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // CTRL fields
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PRE_LSB = 8;
    localparam int CTRL_PRE_W   = 16;

    // CH_k fields
    localparam int CH_MODE_LSB = 0;
    localparam int CH_DUTY_LSB = 8;
    localparam int CH_HALF_LSB = 16;

endpackage
`default_nettype wire

// File: rtl/axil_led_pwm_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_led_pwm_if
// Description : AXI-Lite bus bundle (AW, W, B, AR, R channels).
//               slave modport  : seen from the peripheral.
//               master modport : seen from the bus master.
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_led_pwm_if #(
    parameter int ADDR_W = 6
) ();
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axil_led_pwm_led_chan_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_chan_gen
// Description : One LED channel: off / on / PWM compare / blink, with a
//               registered LED output. Holds the blink counter and phase.
// Ports       : clk_i, rst_ni     - clock, async active-low reset
//               tick_i            - prescaler tick
//               pwm_cnt_i         - shared 8-bit PWM counter
//               mode_i, duty_i    - channel mode and PWM duty
//               half_i            - blink half-period in ticks
//               restart_i         - channel register written this cycle
//               enable_i          - global enable
//               led_o             - registered LED drive
// Revision    : 1.0 - initial release
// ============================================================================
module led_chan_gen
    import axil_led_pkg::*;
(
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        tick_i,
    input  wire logic [7:0]  pwm_cnt_i,
    input  wire logic [1:0]  mode_i,
    input  wire logic [7:0]  duty_i,
    input  wire logic [15:0] half_i,
    input  wire logic        restart_i,
    input  wire logic        enable_i,
    output logic             led_o
);

    logic [15:0] cnt_q;
    logic        phase_q;
    logic        led_q;
    logic        led_d;
    logic [15:0] w_last;

    // H=0 behaves like H=1 (toggle on every tick)
    assign w_last = (half_i == 16'd0) ? 16'd0 : half_i - 16'd1;

    // Phase idles at 1 so a channel always starts its blink lit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (!enable_i || restart_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (tick_i) begin
            // >= so a shrinking H never lets the counter run past the end
            if (cnt_q >= w_last) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        led_d = 1'b0;
        if (enable_i) begin
            case (mode_i)
                MODE_OFF:   led_d = 1'b0;
                MODE_ON:    led_d = 1'b1;
                MODE_PWM:   led_d = (pwm_cnt_i < duty_i);
                MODE_BLINK: led_d = phase_q;
                default:    led_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) led_q <= 1'b0;
        else         led_q <= led_d;
    end

    assign led_o = led_q;

endmodule
`default_nettype wire

// File: rtl/axil_led_pwm.sv
`default_nettype none
// ============================================================================
// Module      : axil_led_pwm
// Description : AXI-Lite slave driving NUM_CH LEDs. Holds the register file,
//               AXI-Lite handshakes, shared tick prescaler and PWM counter.
// Ports       : s_axi_aclk     - clock
//               s_axi_aresetn  - async active-low reset
//               s_axi          - AXI-Lite slave bundle
//               leds           - LED drive, bit k = channel k
// Revision    : 1.0 - initial release
// ============================================================================
module axil_led_pwm
    import axil_led_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH           = 8,
    parameter bit OPT_LOWPOWER     = 1'b0
) (
    input  wire logic         s_axi_aclk,
    input  wire logic         s_axi_aresetn,
    axil_led_pwm_if.slave     s_axi,
    output logic [NUM_CH-1:0] leds
);

    // Register file
    logic                     ctrl_en_q;
    logic [CTRL_PRE_W-1:0]    ctrl_pre_q;
    logic [NUM_CH-1:0][1:0]   mode_q;
    logic [NUM_CH-1:0][7:0]   duty_q;
    logic [NUM_CH-1:0][15:0]  half_q;

    // Bus state
    logic        awready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    // Timebase
    logic [CTRL_PRE_W-1:0] pre_cnt_q;
    logic [7:0]            pwm_cnt_q;

    logic              w_wr_go;
    logic              w_wr_fire;
    logic              w_rd_fire;
    int                w_wr_n;
    int                w_rd_n;
    logic [31:0]       w_rd_data;
    logic [1:0]        w_rd_resp;
    logic              w_tick;
    logic [NUM_CH-1:0] w_restart;
    logic [NUM_CH-1:0] w_leds;
    logic              w_unused;

    assign w_wr_n = int'(s_axi.awaddr[C_AXI_ADDR_WIDTH-1:2]);
    assign w_rd_n = int'(s_axi.araddr[C_AXI_ADDR_WIDTH-1:2]);

    // ---------------- write channel ----------------
    // awready/wready pulse together; the write lands on the cycle they are
    // high (the master holds awvalid/wvalid until then).
    assign w_wr_go   = s_axi.awvalid && s_axi.wvalid && !awready_q &&
                       (!bvalid_q || s_axi.bready);
    assign w_wr_fire = awready_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= w_wr_go;
            if (w_wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (w_wr_n >= ADDR_CH0 + NUM_CH) ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ctrl_en_q  <= 1'b0;
            ctrl_pre_q <= '0;
            mode_q     <= '0;
            duty_q     <= '0;
            half_q     <= '0;
        end else if (w_wr_fire) begin
            if (w_wr_n == ADDR_CTRL) begin
                if (s_axi.wstrb[0]) ctrl_en_q        <= s_axi.wdata[CTRL_EN_BIT];
                if (s_axi.wstrb[1]) ctrl_pre_q[7:0]  <= s_axi.wdata[CTRL_PRE_LSB +: 8];
                if (s_axi.wstrb[2]) ctrl_pre_q[15:8] <= s_axi.wdata[CTRL_PRE_LSB+8 +: 8];
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_wr_n == ADDR_CH0 + k) begin
                    if (s_axi.wstrb[0]) mode_q[k]       <= s_axi.wdata[CH_MODE_LSB +: 2];
                    if (s_axi.wstrb[1]) duty_q[k]       <= s_axi.wdata[CH_DUTY_LSB +: 8];
                    if (s_axi.wstrb[2]) half_q[k][7:0]  <= s_axi.wdata[CH_HALF_LSB +: 8];
                    if (s_axi.wstrb[3]) half_q[k][15:8] <= s_axi.wdata[CH_HALF_LSB+8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_restart = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_restart[k] = w_wr_fire && (w_wr_n == ADDR_CH0 + k);
        end
    end

    // ---------------- read channel ----------------
    assign w_rd_fire = s_axi.arvalid && !rvalid_q;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        if (w_rd_n == ADDR_CTRL) begin
            w_rd_data[CTRL_EN_BIT]                 = ctrl_en_q;
            w_rd_data[CTRL_PRE_LSB +: CTRL_PRE_W]  = ctrl_pre_q;
            w_rd_resp                              = RESP_OKAY;
        end else if (w_rd_n == ADDR_STATUS) begin
            w_rd_data[NUM_CH-1:0] = w_leds;
            w_rd_resp             = RESP_OKAY;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_rd_n == ADDR_CH0 + k) begin
                w_rd_data[CH_MODE_LSB +: 2]  = mode_q[k];
                w_rd_data[CH_DUTY_LSB +: 8]  = duty_q[k];
                w_rd_data[CH_HALF_LSB +: 16] = half_q[k];
                w_rd_resp                    = RESP_OKAY;
            end
        end
    end

    // Sampled before the same-edge write lands, so a colliding read sees
    // the old contents.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (w_rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= w_rd_data;
            rresp_q  <= w_rd_resp;
        end else if (s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // ---------------- timebase ----------------
    // >= keeps the prescaler bounded if P is lowered below the running count.
    assign w_tick = ctrl_en_q && (pre_cnt_q >= ctrl_pre_q);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else if (!ctrl_en_q) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else if (w_tick) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end else begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
        end
    end

    // ---------------- channels ----------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        led_chan_gen u_chan (
            .clk_i     (s_axi_aclk),
            .rst_ni    (s_axi_aresetn),
            .tick_i    (w_tick),
            .pwm_cnt_i (pwm_cnt_q),
            .mode_i    (mode_q[k]),
            .duty_i    (duty_q[k]),
            .half_i    (half_q[k]),
            .restart_i (w_restart[k]),
            .enable_i  (ctrl_en_q),
            .led_o     (w_leds[k])
        );
    end

    // ---------------- outputs ----------------
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = (OPT_LOWPOWER && !rvalid_q) ? 32'd0 : rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign leds          = w_leds;

    // Protection bits, byte offset and spare mode bits carry no meaning here.
    assign w_unused = &{1'b0, s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                        s_axi.araddr[1:0], s_axi.wdata[7:2]};

endmodule
`default_nettype wire

// File: tb/tb_axil_led_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_led_pwm
// Description : Self-checking bench for axil_led_pwm (NUM_CH=8, 6-bit addr).
//               Table of write/readback vectors plus directed sequences for
//               collisions, back-pressure, PWM duty, blink timing and async
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_led_pwm;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] leds;
    int         n_cmp = 0;
    int         n_fail = 0;

    axil_led_pwm_if #(.ADDR_W(6)) bus ();

    axil_led_pwm #(
        .C_AXI_ADDR_WIDTH (6),
        .NUM_CH           (8),
        .OPT_LOWPOWER     (1'b0)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (bus.slave),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int t;
        resp = 2'bxx;
        @(negedge clk);
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
        if (!bus.awready) begin
            tmo("write accept");
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        t = 0;
        while (!bus.bvalid && t < 20) begin @(negedge clk); t++; end
        if (!bus.bvalid) begin tmo("write resp"); return; end
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int t;
        d = 'x; r = 'x;
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = a;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.rvalid && t < 20);
        bus.arvalid = 1'b0;
        if (!bus.rvalid) begin tmo("read"); return; end
        d = bus.rdata; r = bus.rresp;
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [7:0]  leds;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;
        int          t, n;
        logic        seen, lost, bad;

        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;

        //            addr   wdata          strb  bresp rdata          rresp leds
        vecs[0]  = '{6'h00, 32'h0000_0001, 4'hF, OK,  32'h0000_0001, OK,  8'h00};
        vecs[1]  = '{6'h14, 32'h0000_0001, 4'hF, OK,  32'h0000_0001, OK,  8'h08};
        vecs[2]  = '{6'h04, 32'hFFFF_FFFF, 4'hF, OK,  32'h0000_0008, OK,  8'h08};
        vecs[3]  = '{6'h10, 32'hFFFF_FFFF, 4'h2, OK,  32'h0000_FF00, OK,  8'h08};
        vecs[4]  = '{6'h30, 32'hFFFF_FFFF, 4'hF, ERR, 32'h0000_0000, ERR, 8'h08};
        vecs[5]  = '{6'h28, 32'h1234_5678, 4'hF, ERR, 32'h0000_0000, ERR, 8'h08};
        vecs[6]  = '{6'h24, 32'hABCD_5A7F, 4'hF, OK,  32'hABCD_5A03, OK,  8'h88};
        vecs[7]  = '{6'h24, 32'h0000_0000, 4'hF, OK,  32'h0000_0000, OK,  8'h08};
        vecs[8]  = '{6'h08, 32'hFFFF_FFFF, 4'h1, OK,  32'h0000_0003, OK,  8'h09};
        vecs[9]  = '{6'h08, 32'h0000_0000, 4'hF, OK,  32'h0000_0000, OK,  8'h08};
        vecs[10] = '{6'h00, 32'hFFFF_FF00, 4'h6, OK,  32'h00FF_FF01, OK,  8'h08};
        vecs[11] = '{6'h00, 32'h0000_0000, 4'hF, OK,  32'h0000_0000, OK,  8'h00};
        vecs[12] = '{6'h00, 32'h0000_0001, 4'hF, OK,  32'h0000_0001, OK,  8'h08};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("reset leds", 32'(leds), 32'h0);
        chk("reset handshake outs",
            {28'h0, bus.awready, bus.wready, bus.bvalid, bus.rvalid}, 32'h0);
        chk("reset rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;

        for (int w = 0; w < 10; w++) begin
            axi_read(6'(w * 4), rd, rr);
            chk($sformatf("reset read w%0d data", w), rd, 32'h0);
            chk($sformatf("reset read w%0d resp", w), 32'(rr), 32'(OK));
        end

        // ---- table-driven write / readback ----
        for (int i = 0; i < 13; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, br);
            chk($sformatf("vec%0d bresp", i), 32'(br), 32'(vecs[i].bresp));
            chk($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].leds));
            axi_read(vecs[i].addr, rd, rr);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].rdata);
            chk($sformatf("vec%0d rresp", i), 32'(rr), 32'(vecs[i].rresp));
        end
        axi_read(6'h10, rd, rr);
        chk("CH2 after SLVERR writes", rd, 32'h0000_FF00);

        // ---- read and write to the same word in the same cycle ----
        @(negedge clk);
        bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = 6'h1C;
        bus.wdata = 32'h0000_1102; bus.wstrb = 4'hF;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
        if (!bus.awready) tmo("collide accept");
        bus.arvalid = 1; bus.araddr = 6'h1C;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        chk("collide rvalid/bvalid", {30'h0, bus.rvalid, bus.bvalid}, 32'h3);
        chk("collide old data", bus.rdata, 32'h0);
        bus.bready = 1; bus.rready = 1;
        @(negedge clk);
        bus.bready = 0; bus.rready = 0;
        axi_read(6'h1C, rd, rr);
        chk("collide new data", rd, 32'h0000_1102);
        axi_write(6'h1C, 32'h0, 4'hF, br);

        // ---- write back-pressure ----
        @(negedge clk);
        bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = 6'h20;
        bus.wdata = 32'h0000_0100; bus.wstrb = 4'hF; bus.bready = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
        if (!bus.awready) tmo("bp write 1");
        @(negedge clk);
        bus.wdata = 32'h0000_0200;
        seen = 0; lost = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.awready;
            lost |= !bus.bvalid;
        end
        chk("bp no second awready", 32'(seen), 32'h0);
        chk("bp bvalid held", 32'(lost), 32'h0);
        bus.bready = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
        if (!bus.awready) tmo("bp write 2");
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        chk("bp second bvalid", 32'(bus.bvalid), 32'h1);
        @(negedge clk);
        bus.bready = 0;
        axi_read(6'h20, rd, rr);
        chk("bp second data", rd, 32'h0000_0200);

        // ---- read back-pressure ----
        @(negedge clk);
        bus.arvalid = 1; bus.araddr = 6'h20; bus.rready = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.rvalid && t < 20);
        if (!bus.rvalid) tmo("bp read 1");
        bus.araddr = 6'h00;
        seen = 0; lost = 0; bad = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.arready;
            lost |= !bus.rvalid;
            bad  |= (bus.rdata !== 32'h0000_0200);
        end
        chk("bp arready low", 32'(seen), 32'h0);
        chk("bp rvalid held", 32'(lost), 32'h0);
        chk("bp rdata held", 32'(bad), 32'h0);
        bus.rready = 1;
        @(negedge clk);
        t = 0;
        while (!bus.rvalid && t < 20) begin @(negedge clk); t++; end
        bus.arvalid = 0;
        chk("bp second read", bus.rdata, 32'h0000_0001);
        @(negedge clk);
        bus.rready = 0;

        // ---- PWM duty (P=0, tick every cycle) ----
        begin
            logic [31:0] pd [3];
            int          pe [3];
            pd[0] = 32'h0000_4002; pe[0] = 64;
            pd[1] = 32'h0000_0002; pe[1] = 0;
            pd[2] = 32'h0000_FF02; pe[2] = 255;
            for (int i = 0; i < 3; i++) begin
                axi_write(6'h08, pd[i], 4'hF, br);
                n = 0;
                repeat (256) begin
                    @(negedge clk);
                    if (leds[0]) n++;
                end
                chk($sformatf("pwm duty%0d high count", pe[i]), 32'(n), 32'(pe[i]));
            end
            axi_write(6'h08, 32'h0, 4'hF, br);
        end

        // ---- blink, P=3, H=5 ----
        axi_write(6'h00, 32'h0000_0301, 4'hF, br);
        axi_write(6'h0C, 32'h0005_0003, 4'hF, br);
        chk("blink starts high", 32'(leds[1]), 32'h1);
        t = 0;
        while (leds[1] && t < 25) begin @(negedge clk); t++; end
        chk("blink first fall", 32'(leds[1]), 32'h0);
        n = 0;
        while (!leds[1] && n < 40) begin @(negedge clk); n++; end
        chk("blink low period", 32'(n), 32'd20);
        n = 0;
        while (leds[1] && n < 40) begin @(negedge clk); n++; end
        chk("blink high period", 32'(n), 32'd20);

        // ---- async reset with responses pending ----
        @(negedge clk);
        bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = 6'h10;
        bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.bready = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
        if (!bus.awready) tmo("rst write");
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        bus.arvalid = 1; bus.araddr = 6'h00; bus.rready = 0;
        @(negedge clk);
        bus.arvalid = 0;
        chk("pre-reset pending", {29'h0, bus.bvalid, bus.rvalid, leds[3]}, 32'h7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset leds", 32'(leds), 32'h0);
        chk("async reset valids", {30'h0, bus.bvalid, bus.rvalid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi_read(6'h00, rd, rr);
        chk("CTRL after reset", rd, 32'h0);
        axi_read(6'h14, rd, rr);
        chk("CH3 after reset", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
